// File: rtl/video_fx_sync_ctrl_if.sv
// Slot bus for video_fx_sync_ctrl.
// The host (master) drives the chip select, the strobes, the address and the write data.
// The slot (slave) returns combinational read data.
//   cs      : slot select
//   write   : write strobe, qualified by cs
//   read    : read strobe; reads have no side effects
//   addr    : slot address; only addr[1:0] is decoded
//   wr_data : write data
//   rd_data : read data, valid whenever addr is stable
interface video_fx_sync_ctrl_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, write, read, addr, wr_data, input rd_data);
  modport slave  (input cs, write, read, addr, wr_data, output rd_data);
endinterface

// File: rtl/video_fx_sync_ctrl.sv
// Frame-synchronous configuration controller for the video effect cores.
// Host writes to the shadow bypass mask are held until a frame boundary.
// At the boundary they are committed to the live bypass mask in a single edge.
// A host command can also force an immediate commit.
// An optional auto-cycle mode XORs a toggle mask into the live mask every P frames.
//   clk        : system clock
//   reset      : asynchronous, active-high
//   x, y       : global frame-counter column / row
//   bus        : slot bus (cs/write/read/addr/wr_data in, rd_data out)
//   bypass     : live bypass mask, 1 = core bypassed
//   frame_tick : one-clk pulse on the first cycle of the commit pixel
//   pending    : shadow mask awaiting commit
module video_fx_sync_ctrl #(
  parameter int N_CORES   = 4,
  parameter int H_SYNC_PT = 0,
  parameter int V_SYNC_PT = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  video_fx_sync_ctrl_if.slave    bus,
  output logic [N_CORES-1:0]     bypass,
  output logic                   frame_tick,
  output logic                   pending
);

  localparam logic [10:0] H_PT = 11'(H_SYNC_PT);
  localparam logic [10:0] V_PT = 11'(V_SYNC_PT);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t               state, state_nxt;
  logic                 hit, hit_q;
  logic [N_CORES-1:0]   shadow, shadow_nxt;
  logic [N_CORES-1:0]   toggle_mask;
  logic                 auto_en;
  logic [7:0]           period;
  logic [7:0]           cnt;
  logic [7:0]           fcnt;
  logic                 wr_en, wr_mask, wr_mode, wr_cmd;
  logic                 commit, toggle_now;
  logic                 unused_bits;

  assign unused_bits = ^{bus.read, bus.addr[13:2], bus.wr_data};

  // x/y hold for several clocks per pixel; the edge detect yields one tick per frame.
  assign hit        = (x == H_PT) && (y == V_PT);
  assign frame_tick = hit & ~hit_q;

  assign wr_en   = bus.cs & bus.write;
  assign wr_mask = wr_en && (bus.addr[1:0] == 2'd0);
  assign wr_mode = wr_en && (bus.addr[1:0] == 2'd1);
  assign wr_cmd  = wr_en && (bus.addr[1:0] == 2'd2) && bus.wr_data[0];

  // A mask write landing on the tick commits straight through.
  // For that reason the committed value is always the post-write shadow.
  assign shadow_nxt = wr_mask ? bus.wr_data[N_CORES-1:0] : shadow;
  assign commit     = wr_cmd | (frame_tick & ((state == ARMED) | wr_mask));
  assign toggle_now = frame_tick & auto_en & (cnt == period);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_mask && !commit) state_nxt = ARMED;
      ARMED:   if (commit)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pending = (state == ARMED);
  end

  // Configuration, live mask and frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q       <= 1'b1;
      shadow      <= '1;
      bypass      <= '1;
      auto_en     <= 1'b0;
      period      <= 8'd0;
      toggle_mask <= '0;
      cnt         <= 8'd0;
      fcnt        <= 8'd0;
    end else begin
      hit_q  <= hit;
      shadow <= shadow_nxt;

      // A commit beats the auto toggle on the same tick.
      if (commit)          bypass <= shadow_nxt;
      else if (toggle_now) bypass <= bypass ^ toggle_mask;

      if (commit || wr_mode)          cnt <= 8'd0;
      else if (frame_tick && auto_en) cnt <= (cnt == period) ? 8'd0 : cnt + 8'd1;

      if (commit)                           fcnt <= 8'd0;
      else if (frame_tick && fcnt != 8'hFF) fcnt <= fcnt + 8'd1;

      if (wr_mode) begin
        auto_en     <= bus.wr_data[0];
        period      <= bus.wr_data[8:1];
        toggle_mask <= bus.wr_data[16 +: N_CORES];
      end
    end
  end

  // Read mux
  always_comb begin
    bus.rd_data = '0;
    case (bus.addr[1:0])
      2'd0: bus.rd_data[N_CORES-1:0] = shadow;
      2'd1: begin
        bus.rd_data[0]             = auto_en;
        bus.rd_data[8:1]           = period;
        bus.rd_data[16 +: N_CORES] = toggle_mask;
      end
      2'd3: begin
        bus.rd_data[N_CORES-1:0] = bypass;
        bus.rd_data[8]           = pending;
        bus.rd_data[23:16]       = fcnt;
      end
      default: bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_video_fx_sync_ctrl.sv
module tb_video_fx_sync_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] x, y;
  logic [3:0]  bypass;
  logic        frame_tick;
  logic        pending;

  video_fx_sync_ctrl_if bus();

  video_fx_sync_ctrl #(.N_CORES(4), .H_SYNC_PT(0), .V_SYNC_PT(480)) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .bus        (bus),
    .bypass     (bypass),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        s_tick, s_pend;
  logic [3:0]  s_byp;
  logic [31:0] s_rd;

  typedef struct {
    logic        cs, wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [10:0] xi, yi;
    logic        tick;
    logic [3:0]  byp;
    logic        pend;
    logic        rc;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vw(logic [1:0] a, logic [31:0] d, logic [10:0] xi, yi,
                              logic tick, logic [3:0] byp, logic pend);
    vec_t v;
    v.cs = 1; v.wr = 1; v.a = a; v.d = d; v.xi = xi; v.yi = yi;
    v.tick = tick; v.byp = byp; v.pend = pend; v.rc = 0; v.rd = 0;
    return v;
  endfunction

  function automatic vec_t vr(logic [1:0] a, logic [10:0] xi, yi,
                              logic tick, logic [3:0] byp, logic pend, logic [31:0] rd);
    vec_t v;
    v.cs = 1; v.wr = 0; v.a = a; v.d = 0; v.xi = xi; v.yi = yi;
    v.tick = tick; v.byp = byp; v.pend = pend; v.rc = 1; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t vi(logic [10:0] xi, yi, logic tick, logic [3:0] byp, logic pend);
    vec_t v;
    v.cs = 0; v.wr = 0; v.a = 0; v.d = 0; v.xi = xi; v.yi = yi;
    v.tick = tick; v.byp = byp; v.pend = pend; v.rc = 0; v.rd = 0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts and ends at posedge+1: combinational outputs are sampled at the negedge,
  // registered outputs at the following posedge+1.
  task automatic cyc(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [10:0] xi, input logic [10:0] yi);
    bus.cs = c; bus.write = w; bus.read = c & ~w;
    bus.addr = {12'h000, a}; bus.wr_data = d; x = xi; y = yi;
    @(negedge clk);
    s_tick = frame_tick;
    s_rd   = bus.rd_data;
    @(posedge clk);
    #1;
    s_byp  = bypass;
    s_pend = pending;
  endtask

  // Behavioural reference model
  int m_byp, m_shadow, m_pend, m_auto, m_per, m_tog, m_cnt, m_fcnt, m_prev_hit;

  task automatic m_reset();
    m_byp = 15; m_shadow = 15; m_pend = 0; m_auto = 0; m_per = 0; m_tog = 0;
    m_cnt = 0; m_fcnt = 0; m_prev_hit = 1;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_shadow);
      2'd1:    return 32'((m_tog << 16) + (m_per << 1) + m_auto);
      2'd2:    return 32'd0;
      default: return 32'((m_fcnt << 16) + (m_pend << 8) + m_byp);
    endcase
  endfunction

  task automatic m_clock(input logic c, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input bit tick);
    bit wm, wmo, wc, com;
    int new_sh;
    wm  = c && w && a == 2'd0;
    wmo = c && w && a == 2'd1;
    wc  = c && w && a == 2'd2 && d[0];
    new_sh = wm ? int'(d[3:0]) : m_shadow;
    com = wc || (tick && (m_pend == 1 || wm));
    if (com) begin
      m_byp = new_sh; m_cnt = 0; m_fcnt = 0; m_pend = 0;
    end else begin
      if (tick) begin
        m_fcnt = (m_fcnt == 255) ? 255 : m_fcnt + 1;
        if (m_auto == 1) begin
          if (m_cnt == m_per) begin m_byp = m_byp ^ m_tog; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
        end
      end
      if (wm) m_pend = 1;
    end
    m_shadow = new_sh;
    if (wmo) begin
      m_auto = int'(d[0]); m_per = int'(d[8:1]); m_tog = int'(d[19:16]); m_cnt = 0;
    end
  endtask

  task automatic do_reset(input logic [10:0] xi, input logic [10:0] yi);
    bus.cs = 0; bus.write = 0; bus.read = 0; bus.addr = 0; bus.wr_data = 0;
    x = xi; y = yi;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [10:0] px, py;
    bit          exp_tick;
    logic [31:0] exp_rd, d;
    logic [1:0]  a;
    logic        c, w;
    int          op, p;

    // Directed vector table (N_CORES = 4)
    vecs.push_back(vr(3, 5, 0,    0, 4'hF, 0, 32'h0000_000F));
    vecs.push_back(vi(0, 480,     1, 4'hF, 0));
    vecs.push_back(vi(0, 480,     0, 4'hF, 0));
    vecs.push_back(vi(1, 480,     0, 4'hF, 0));
    vecs.push_back(vi(0, 480,     1, 4'hF, 0));
    vecs.push_back(vr(3, 5, 0,    0, 4'hF, 0, 32'h0002_000F));
    vecs.push_back(vw(0, 32'h5, 5, 100, 0, 4'hF, 1));
    vecs.push_back(vr(0, 5, 100,  0, 4'hF, 1, 32'h0000_0005));
    vecs.push_back(vr(3, 5, 100,  0, 4'hF, 1, 32'h0002_010F));
    vecs.push_back(vi(0, 480,     1, 4'h5, 0));
    vecs.push_back(vi(0, 480,     0, 4'h5, 0));
    vecs.push_back(vi(0, 480,     0, 4'h5, 0));
    vecs.push_back(vi(0, 480,     0, 4'h5, 0));
    vecs.push_back(vr(3, 1, 480,  0, 4'h5, 0, 32'h0000_0005));
    vecs.push_back(vw(0, 32'h3, 1, 480, 0, 4'h5, 1));
    vecs.push_back(vw(0, 32'h8, 1, 480, 0, 4'h5, 1));
    vecs.push_back(vi(0, 480,     1, 4'h8, 0));
    vecs.push_back(vi(1, 480,     0, 4'h8, 0));
    vecs.push_back(vw(0, 32'h6, 0, 480, 1, 4'h6, 0));
    vecs.push_back(vr(3, 0, 480,  0, 4'h6, 0, 32'h0000_0006));
    vecs.push_back(vw(0, 32'h0, 5, 10, 0, 4'h6, 1));
    vecs.push_back(vw(2, 32'h1, 5, 10, 0, 4'h0, 0));
    vecs.push_back(vr(3, 5, 10,   0, 4'h0, 0, 32'h0000_0000));
    vecs.push_back(vw(1, 32'h0001_0005, 5, 10, 0, 4'h0, 0));
    vecs.push_back(vr(1, 5, 10,   0, 4'h0, 0, 32'h0001_0005));
    vecs.push_back(vi(0, 480, 1, 4'h0, 0));
    vecs.push_back(vi(1, 480, 0, 4'h0, 0));
    vecs.push_back(vi(0, 480, 1, 4'h0, 0));
    vecs.push_back(vi(1, 480, 0, 4'h0, 0));
    vecs.push_back(vi(0, 480, 1, 4'h1, 0));
    vecs.push_back(vi(1, 480, 0, 4'h1, 0));
    vecs.push_back(vi(0, 480, 1, 4'h1, 0));
    vecs.push_back(vi(1, 480, 0, 4'h1, 0));
    vecs.push_back(vi(0, 480, 1, 4'h1, 0));
    vecs.push_back(vw(0, 32'hA, 1, 480, 0, 4'h1, 1));
    vecs.push_back(vi(0, 480, 1, 4'hA, 0));
    vecs.push_back(vi(1, 480, 0, 4'hA, 0));
    vecs.push_back(vi(0, 480, 1, 4'hA, 0));
    vecs.push_back(vi(1, 480, 0, 4'hA, 0));
    vecs.push_back(vi(0, 480, 1, 4'hA, 0));
    vecs.push_back(vi(1, 480, 0, 4'hA, 0));
    vecs.push_back(vi(0, 480, 1, 4'hB, 0));
    vecs.push_back(vi(1, 480, 0, 4'hB, 0));
    vecs.push_back(vw(1, 32'h0, 1, 480, 0, 4'hB, 0));
    vecs.push_back(vi(0, 480, 1, 4'hB, 0));
    vecs.push_back(vi(1, 480, 0, 4'hB, 0));
    vecs.push_back(vi(0, 480, 1, 4'hB, 0));
    vecs.push_back(vi(1, 480, 0, 4'hB, 0));
    vecs.push_back(vi(0, 480, 1, 4'hB, 0));
    vecs.push_back(vw(3, 32'hFFFF_FFFF, 5, 0, 0, 4'hB, 0));
    vecs.push_back(vr(3, 5, 0,    0, 4'hB, 0, 32'h0006_000B));
    vecs.push_back(vw(2, 32'h1, 5, 0, 0, 4'hA, 0));
    vecs.push_back(vr(3, 5, 0,    0, 4'hA, 0, 32'h0000_000A));

    do_reset(5, 0);
    chk("reset_bypass", 32'(bypass), 32'hF);
    chk("reset_pending", 32'(pending), 32'h0);

    foreach (vecs[i]) begin
      cyc(vecs[i].cs, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].xi, vecs[i].yi);
      chk($sformatf("vec%0d_tick", i), 32'(s_tick), 32'(vecs[i].tick));
      chk($sformatf("vec%0d_bypass", i), 32'(s_byp), 32'(vecs[i].byp));
      chk($sformatf("vec%0d_pending", i), 32'(s_pend), 32'(vecs[i].pend));
      if (vecs[i].rc) chk($sformatf("vec%0d_rd", i), s_rd, vecs[i].rd);
    end

    // Reset while ARMED discards the shadow; the next boundary commits nothing
    cyc(1, 1, 0, 32'h3, 5, 300);
    chk("armed_pending", 32'(s_pend), 32'h1);
    reset = 1'b1;
    #2;
    chk("async_reset_bypass", 32'(bypass), 32'hF);
    chk("async_reset_pending", 32'(pending), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(0, 0, 0, 0, 5, 300);
    cyc(0, 0, 0, 0, 0, 480);
    chk("post_reset_tick", 32'(s_tick), 32'h1);
    chk("post_reset_no_commit", 32'(s_byp), 32'hF);
    chk("post_reset_pending", 32'(s_pend), 32'h0);
    cyc(1, 0, 0, 0, 0, 480);
    chk("post_reset_shadow", s_rd, 32'hF);

    // Reset released on the boundary pixel gives no tick
    do_reset(0, 480);
    cyc(0, 0, 0, 0, 0, 480);
    chk("release_on_boundary_tick", 32'(s_tick), 32'h0);
    cyc(0, 0, 0, 0, 1, 480);
    cyc(0, 0, 0, 0, 0, 480);
    chk("first_real_tick", 32'(s_tick), 32'h1);

    // Frame count saturates at 255
    for (int i = 0; i < 260; i++) begin
      cyc(0, 0, 0, 0, 1, 480);
      cyc(0, 0, 0, 0, 0, 480);
    end
    cyc(1, 0, 3, 0, 5, 0);
    chk("fcnt_saturate", s_rd, 32'h00FF_000F);

    // Randomized run against the reference model
    do_reset(5, 0);
    m_reset();
    px = 5; py = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 4);
        case (p)
          0, 4: begin px = 0; py = 480; end
          1:    begin px = 1; py = 480; end
          2:    begin px = 0; py = 479; end
          default: begin px = 7; py = 100; end
        endcase
      end
      op = $urandom_range(0, 19);
      c = 1; w = 1; d = $urandom;
      a = 2'($urandom_range(0, 3));
      if (op < 7) begin c = 0; w = 0; end
      else if (op < 10) a = 0;
      else if (op < 12) begin a = 1; d = (d & 32'h00FF_0000) | 32'($urandom_range(0, 3) << 1) | 32'($urandom_range(0, 1)); end
      else if (op < 13) a = 2;
      else if (op < 14) a = 3;
      else w = 0;
      exp_tick = ((px == 0) && (py == 480)) && (m_prev_hit == 0);
      m_prev_hit = ((px == 0) && (py == 480)) ? 1 : 0;
      exp_rd = m_read(a);
      cyc(c, w, a, d, px, py);
      m_clock(c, w, a, d, exp_tick);
      chk($sformatf("rnd%0d_tick", i), 32'(s_tick), 32'(exp_tick));
      chk($sformatf("rnd%0d_rd", i), s_rd, exp_rd);
      chk($sformatf("rnd%0d_bypass", i), 32'(s_byp), 32'(m_byp));
      chk($sformatf("rnd%0d_pending", i), 32'(s_pend), 32'(m_pend));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
